// File: rtl/cost_display_ctrl_if.sv
// Cost readout bundle: conversion request/status from the accumulator side plus the display pins.
interface cost_display_ctrl_if;
  logic [13:0] cost;
  logic        load;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (output cost, load, input busy, done, ovf, an, seg, dp);
  modport slave  (input cost, load, output busy, done, ovf, an, seg, dp);
endinterface

// File: rtl/cost_display_ctrl.sv
// Cost readout: 14-bit cents -> 4 BCD digits via shift-add-3, then common-anode 4-digit scan.
// COST_DISPLAY_LZB_EN blanks the dollar-tens digit when it is zero.
module cost_display_ctrl #(
  parameter int SCAN_DIV = 100000
) (
  input logic                 clk,
  input logic                 rst,
  cost_display_ctrl_if.slave  ctrl
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [13:0] MAX_COST = 14'd9999;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state, state_nx;
  logic [13:0]   bin;
  logic [15:0]   bcd;
  logic [3:0]    cnt;
  logic          ovf_pend;
  logic          commit;

  logic [15:0]   digits, dig_nx;
  logic          ovf_q;
  logic [PW-1:0] presc;
  logic [1:0]    idx, idx_nx;
  logic          wrap;
  logic [3:0]    sel;
  logic [6:0]    seg_nx;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic [29:0]   step;

  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // The SHIFT state spends one extra cycle at cnt==14 so the commit edge
  // coincides with entry to DONE, making new digits visible while done is high.
  always_comb begin
    state_nx = state;
    commit   = 1'b0;
    case (state)
      IDLE:  if (ctrl.load) state_nx = SHIFT;
      SHIFT: if (cnt == 4'd14) begin
        state_nx = DONE;
        commit   = 1'b1;
      end
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign step = {add3(bcd), bin};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
    end else if (state == IDLE && ctrl.load) begin
      bin      <= (ctrl.cost > MAX_COST) ? MAX_COST : ctrl.cost;
      bcd      <= '0;
      cnt      <= '0;
      ovf_pend <= (ctrl.cost > MAX_COST);
    end else if (state == SHIFT && cnt != 4'd14) begin
      {bcd, bin} <= {step[28:0], 1'b0};
      cnt        <= cnt + 4'd1;
    end
  end

  always_comb begin
    wrap   = (presc == PW'(SCAN_DIV - 1));
    idx_nx = wrap ? idx + 2'd1 : idx;
    dig_nx = commit ? bcd : digits;
    sel    = dig_nx[{idx_nx, 2'b00} +: 4];
    seg_nx = seg7(sel);
`ifdef COST_DISPLAY_LZB_EN
    if (idx_nx == 2'd3 && sel == 4'd0) seg_nx = 7'b1111111;
`endif
  end

  // Display pins are registered from next-state values so a commit shows up
  // on the currently lit digit without disturbing the scan position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      idx    <= '0;
      digits <= '0;
      ovf_q  <= 1'b0;
      an_q   <= 4'b1110;
      seg_q  <= 7'b1000000;
      dp_q   <= 1'b1;
    end else begin
      presc <= wrap ? '0 : presc + PW'(1);
      idx   <= idx_nx;
      if (commit) begin
        digits <= bcd;
        ovf_q  <= ovf_pend;
      end
      an_q  <= ~(4'b0001 << idx_nx);
      seg_q <= seg_nx;
      dp_q  <= (idx_nx != 2'd2);
    end
  end

  assign ctrl.busy = (state != IDLE);
  assign ctrl.done = (state == DONE);
  assign ctrl.ovf  = ovf_q;
  assign ctrl.an   = an_q;
  assign ctrl.seg  = seg_q;
  assign ctrl.dp   = dp_q;

endmodule
